// File: rtl/dvp_pkg.sv
// -----------------------------------------------------------------------------
// dvp_pkg
// Shared definitions for the DVP test-pattern transmitter:
//   - pattern_sel encodings (PAT_BARS, PAT_GRAD, PAT_CHECK, PAT_SOLID)
//   - the eight RGB565 colour-bar constants and a bar-index lookup
//   - default frame geometry, matching the ov5640_dri capture path
// -----------------------------------------------------------------------------
package dvp_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    localparam logic [15:0] COL_WHITE   = 16'hFFFF;
    localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COL_CYAN    = 16'h07FF;
    localparam logic [15:0] COL_GREEN   = 16'h07E0;
    localparam logic [15:0] COL_MAGENTA = 16'hF81F;
    localparam logic [15:0] COL_RED     = 16'hF800;
    localparam logic [15:0] COL_BLUE    = 16'h001F;
    localparam logic [15:0] COL_BLACK   = 16'h0000;

    localparam int DEF_H_ACTIVE    = 1024;
    localparam int DEF_V_ACTIVE    = 768;
    localparam int DEF_H_BLANK     = 1216;
    localparam int DEF_V_BLANK     = 504;
    localparam int DEF_VSYNC_LINES = 4;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_if.sv
// -----------------------------------------------------------------------------
// dvp_if
// Camera-side DVP bus as produced by an OV5640-style sensor.
//   cam_vsync : frame sync, active high
//   cam_href  : line valid
//   cam_data  : 8-bit pixel byte (RGB565, high byte first)
// Modports: master (the transmitter), slave (the capture side).
// -----------------------------------------------------------------------------
interface dvp_if;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    modport master (output cam_vsync, output cam_href, output cam_data);
    modport slave  (input  cam_vsync, input  cam_href, input  cam_data);
endinterface

// File: rtl/dvp_pattern_gen.sv
// -----------------------------------------------------------------------------
// dvp_pattern_gen
// Combinational RGB565 test-pattern pixel function.
// Ports:
//   x, y        in  16  pixel coordinates inside the active window
//   pattern     in  2   selected pattern (dvp_pkg::pattern_e)
//   solid_color in  16  colour for PAT_SOLID
//   pix         out 16  RGB565 pixel
// -----------------------------------------------------------------------------
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  pattern_e    pattern,
    input  logic [15:0] solid_color,
    output logic [15:0] pix
);

    // Eight equal-width bars across the active line.
    logic [31:0] bar_idx;
    assign bar_idx = (32'(x) << 3) / 32'(H_ACTIVE);

    // Only y[4] and the low bar-index bits matter.
    logic unused_bits;
    assign unused_bits = ^{y[15:5], y[3:0], bar_idx[31:3]};

    always_comb begin
        pix = 16'h0000;
        case (pattern)
            PAT_BARS:  pix = bar_color(bar_idx[2:0]);
            PAT_GRAD:  pix = {x[4:0], x[5:0], x[4:0]};
            PAT_CHECK: pix = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
            PAT_SOLID: pix = solid_color;
            default:   pix = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// -----------------------------------------------------------------------------
// dvp_pattern_tx
// OV5640-style DVP transmitter that streams RGB565 test patterns, used in
// place of the sensor to drive the ov5640_dri capture path.
// Ports:
//   clk          in   1   pixel clock (cam_pclk equivalent)
//   rst          in   1   asynchronous, active-high reset
//   en           in   1   run request; a started frame always completes
//   pattern_sel  in   2   0 bars, 1 gradient, 2 checkerboard, 3 solid
//   solid_color  in  16   RGB565 colour for the solid pattern
//   cam          dvp_if.master  cam_vsync / cam_href / cam_data
//   frame_done   out  1   pulse on the cycle after the last active byte
//   frame_cnt    out 16   completed-frame counter (wraps)
//   busy         out  1   high while a frame is in progress
// Optional feature: define DVP_FRAME_STAMP_EN to replace pixel (0,0) of each
// frame with the current frame_cnt value.
// -----------------------------------------------------------------------------
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_BLANK     = DEF_V_BLANK,
    parameter int VSYNC_LINES = DEF_VSYNC_LINES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   pattern_sel,
    input  logic [15:0]  solid_color,
    dvp_if.master        cam,
    output logic         frame_done,
    output logic [15:0]  frame_cnt,
    output logic         busy
);

    localparam int L  = 2 * H_ACTIVE + H_BLANK;
    localparam int F  = V_BLANK + V_ACTIVE;
    localparam int HW = $clog2(L);
    localparam int VW = $clog2(F);

    localparam logic [HW-1:0] H_LAST   = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT2   = HW'(2 * H_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(F - 1);
    localparam logic [VW-1:0] VBLANK_V = VW'(V_BLANK);
    localparam logic [VW-1:0] VSYNC_V  = VW'(VSYNC_LINES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    pattern_e      pat_q;
    logic [15:0]   solid_q;

    logic run, h_last, frame_end, frame_start;
    assign run         = (state == S_RUN);
    assign h_last      = (h_cnt == H_LAST);
    assign frame_end   = run && h_last && (v_cnt == V_LAST);
    assign frame_start = en && (!run || frame_end);
    assign busy        = run;

    // ---- stage 0: frame FSM and raster counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
            if (en) state <= S_RUN;
        end else if (h_last) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
                state <= en ? S_RUN : S_IDLE;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Pattern selection is frozen for a whole frame.
    always_ff @(posedge clk) begin
        if (frame_start) begin
            pat_q   <= pattern_e'(pattern_sel);
            solid_q <= solid_color;
        end
    end

    logic vsync_int, href_int, last_byte_int;
    assign vsync_int     = run && (v_cnt < VSYNC_V);
    assign href_int      = run && (v_cnt >= VBLANK_V) && (h_cnt < H_ACT2);
    assign last_byte_int = run && (v_cnt == V_LAST) && (h_cnt == H_ACT2 - 1'b1);

    logic [15:0] x, y, pix, pix_sel;
    assign x = 16'(h_cnt[HW-1:1]);
    assign y = 16'(v_cnt - VBLANK_V);

    dvp_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_gen (
        .x           (x),
        .y           (y),
        .pattern     (pat_q),
        .solid_color (solid_q),
        .pix         (pix)
    );

`ifdef DVP_FRAME_STAMP_EN
    // Pixel (0,0) carries the number of frames completed so far.
    assign pix_sel = ((v_cnt == VBLANK_V) && (h_cnt < HW'(2))) ? frame_cnt : pix;
`else
    assign pix_sel = pix;
`endif

    // ---- stage 1: registered sync/data, one cycle behind the counters ----
    logic       vsync_p1, href_p1, last_p1;
    logic [7:0] data_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
            data_p1  <= 8'h00;
            last_p1  <= 1'b0;
        end else begin
            vsync_p1 <= vsync_int;
            href_p1  <= href_int;
            data_p1  <= href_int ? (h_cnt[0] ? pix_sel[7:0] : pix_sel[15:8]) : 8'h00;
            last_p1  <= last_byte_int;
        end
    end

    // ---- stage 2: end-of-frame pulse and frame counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            frame_done <= last_p1;
            if (last_p1) frame_cnt <= frame_cnt + 16'h0001;
        end
    end

    assign cam.cam_vsync = vsync_p1;
    assign cam.cam_href  = href_p1;
    assign cam.cam_data  = data_p1;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_dvp_pattern_tx
// Directed bench for dvp_pattern_tx on a small geometry: 8x4 active,
// H_BLANK=6, V_BLANK=3, VSYNC_LINES=1 -> 22 cycles/line, 154 cycles/frame.
// Cycle 0 of a frame is the first cycle after the edge that enters RUN.
// -----------------------------------------------------------------------------
module tb_dvp_pattern_tx;
    import dvp_pkg::*;

    localparam int HA = 8, VA = 4, HB = 6, VB = 3, VS = 1;
    localparam int FR = 154;

`ifdef DVP_FRAME_STAMP_EN
    localparam bit STAMP = 1'b1;
`else
    localparam bit STAMP = 1'b0;
`endif

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        frame_done, busy;
    logic [15:0] frame_cnt;

    dvp_if cam ();

    dvp_pattern_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB), .VSYNC_LINES(VS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .cam         (cam.master),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-frame observations
    int          vs_cnt, vs_first, hr_cnt, hr_first, hr_rises;
    int          fd_cnt, fd_cycle, bad_data;
    logic        busy_end, prev_href;
    logic [15:0] cnt_start, cnt_end;
    logic [7:0]  bytes [64];

    task automatic run_frame(input int act, input logic [1:0] np, input logic ne);
        vs_cnt = 0; vs_first = -1; hr_cnt = 0; hr_first = -1; hr_rises = 0;
        fd_cnt = 0; fd_cycle = -1; bad_data = 0; prev_href = 1'b0;
        for (int c = 0; c < FR; c++) begin
            tick();
            if (c == 0) cnt_start = frame_cnt;
            if (cam.cam_vsync) begin
                if (vs_cnt == 0) vs_first = c;
                vs_cnt++;
            end
            if (cam.cam_href) begin
                if (hr_cnt == 0) hr_first = c;
                if (!prev_href) hr_rises++;
                if (hr_cnt < 64) bytes[hr_cnt] = cam.cam_data;
                hr_cnt++;
            end else if (cam.cam_data != 8'h00) begin
                bad_data++;
            end
            prev_href = cam.cam_href;
            if (frame_done) begin
                fd_cnt++;
                fd_cycle = c;
            end
            if (c == act) begin
                pattern_sel = np;
                en = ne;
            end
        end
        cnt_end  = frame_cnt;
        busy_end = busy;
    endtask

    function automatic logic [7:0] exp_byte(input int kind, input int i, input logic [15:0] stamp);
        int          xx;
        logic [15:0] pix;
        xx = (i % 16) / 2;
        case (kind)
            0:       pix = BARS[xx];
            2:       pix = 16'h0000;
            default: pix = 16'h1234;
        endcase
        if (STAMP && i < 2) pix = stamp;
        return (i % 2 == 0) ? pix[15:8] : pix[7:0];
    endfunction

    task automatic check_frame(input string tag, input int kind, input logic [15:0] stamp);
        check({tag, "_vs_cnt"},   vs_cnt,   22);
        check({tag, "_vs_first"}, vs_first, 1);
        check({tag, "_hr_first"}, hr_first, 67);
        check({tag, "_hr_cnt"},   hr_cnt,   64);
        check({tag, "_hr_lines"}, hr_rises, 4);
        check({tag, "_idle_data"}, bad_data, 0);
        check({tag, "_fd_cnt"},   fd_cnt,   1);
        check({tag, "_fd_cycle"}, fd_cycle, 149);
        check({tag, "_cnt_start"}, cnt_start, stamp);
        check({tag, "_cnt_end"},  cnt_end,  stamp + 16'h0001);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s_byte%0d", tag, i), bytes[i], exp_byte(kind, i, stamp));
    endtask

    initial begin
        int vs_seen, busy_seen;
        rst = 1'b1; en = 1'b0; pattern_sel = 2'd0; solid_color = 16'h0000;
        repeat (3) tick();
        check("rst_vsync", cam.cam_vsync, 0);
        check("rst_href",  cam.cam_href,  0);
        check("rst_data",  cam.cam_data,  0);
        check("rst_fdone", frame_done,    0);
        check("rst_fcnt",  frame_cnt,     0);
        check("rst_busy",  busy,          0);

        rst = 1'b0;
        repeat (3) tick();
        check("idle_busy",  busy, 0);
        check("idle_vsync", cam.cam_vsync, 0);

        // Frame 0: colour bars; queue solid for the next frame at its last cycle.
        en = 1'b1; pattern_sel = 2'd0; solid_color = 16'h1234;
        run_frame(153, 2'd3, 1'b1);
        check_frame("f0_bars", 0, 16'h0000);
        check("f0_busy_end", busy_end, 1);

        // Frame 1: solid, en dropped 10 cycles in; frame still completes.
        run_frame(10, 2'd3, 1'b0);
        check_frame("f1_solid", 3, 16'h0001);
        check("f1_busy_end", busy_end, 1);
        tick();
        check("f1_busy_fall", busy, 0);
        vs_seen = 0; busy_seen = 0;
        repeat (60) begin
            tick();
            if (cam.cam_vsync) vs_seen++;
            if (busy) busy_seen++;
        end
        check("stop_vsync", vs_seen, 0);
        check("stop_busy",  busy_seen, 0);
        check("stop_fcnt",  frame_cnt, 16'h0002);

        // Frame 2: bars with a mid-frame switch to checkerboard; frame 3 checker.
        pattern_sel = 2'd0; en = 1'b1;
        run_frame(10, 2'd2, 1'b1);
        check_frame("f2_bars", 0, 16'h0002);
        run_frame(153, 2'd3, 1'b1);
        check_frame("f3_check", 2, 16'h0003);

        // Frame 4 (solid): reset in the middle of an active line.
        repeat (71) tick();
        check("pre_rst_href",  cam.cam_href, 1);
        check("pre_rst_data",  cam.cam_data, 8'h34);
        check("pre_rst_busy",  busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_vsync", cam.cam_vsync, 0);
        check("arst_href",  cam.cam_href,  0);
        check("arst_data",  cam.cam_data,  0);
        check("arst_fdone", frame_done,    0);
        check("arst_fcnt",  frame_cnt,     0);
        check("arst_busy",  busy,          0);
        repeat (2) tick();
        rst = 1'b0;

        // Restart: three solid frames, stamped 0,1,2 when stamping is built in.
        run_frame(-1, 2'd3, 1'b1);
        check_frame("r0_solid", 3, 16'h0000);
        run_frame(-1, 2'd3, 1'b1);
        check_frame("r1_solid", 3, 16'h0001);
        run_frame(-1, 2'd3, 1'b1);
        check_frame("r2_solid", 3, 16'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
